// File: rtl/me_search_ctrl.sv
// me_search_ctrl
// Sequencer for the full-search motion-estimation datapath. Walks the
// candidate columns of one search window, one column per accepted
// compare_tree result, keeps a running minimum SAD and hands the winning
// (x, y, SAD) to the vector store over a valid/ready handshake.
// Every output is a flop, so no input reaches an output combinationally.

module me_search_ctrl #(
  parameter int SAD_W = 14,
  parameter int MV_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             col_req,
  output logic [MV_W-1:0]  col_idx,
  input  logic             col_vld,
  input  logic [SAD_W-1:0] sad_cmp,
  input  logic [MV_W-1:0]  mv_y,
  output logic             best_vld,
  input  logic             best_rdy,
  output logic [SAD_W-1:0] best_sad,
  output logic [MV_W-1:0]  best_mv_x,
  output logic [MV_W-1:0]  best_mv_y
);

  // The last candidate column is the all-ones index (2^MV_W - 1).
  localparam logic [MV_W-1:0] LAST_COL = '1;
  localparam logic [MV_W-1:0] ONE_COL  = MV_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [MV_W-1:0]  col_idx_q, col_idx_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [MV_W-1:0]  best_mv_x_q, best_mv_x_d;
  logic [MV_W-1:0]  best_mv_y_q, best_mv_y_d;
  logic             busy_q, busy_d;
  logic             col_req_q, col_req_d;
  logic             best_vld_q, best_vld_d;

  // Next-state, column walk and running-minimum update.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    best_sad_d  = best_sad_q;
    best_mv_x_d = best_mv_x_q;
    best_mv_y_d = best_mv_y_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_idx_d = '0;
          state_d   = REQ;
        end
      end

      REQ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (col_vld) begin
          // Column 0 always seeds the running best; later columns replace it
          // only when strictly smaller, so ties keep the lower x.
          if ((col_idx_q == '0) || (sad_cmp < best_sad_q)) begin
            best_sad_d  = sad_cmp;
            best_mv_x_d = col_idx_q;
            best_mv_y_d = mv_y;
          end
          if (col_idx_q == LAST_COL) begin
            state_d = OUT;
          end else begin
            col_idx_d = col_idx_q + ONE_COL;
          end
        end
      end

      OUT: begin
        if (abort || best_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state and registered.
  always_comb begin
    busy_d     = (state_d == REQ) || (state_d == OUT);
    col_req_d  = (state_d == REQ);
    best_vld_d = (state_d == OUT);
  end

  // State, column index, best-result and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_idx_q   <= '0;
      best_sad_q  <= '0;
      best_mv_x_q <= '0;
      best_mv_y_q <= '0;
      busy_q      <= 1'b0;
      col_req_q   <= 1'b0;
      best_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      best_sad_q  <= best_sad_d;
      best_mv_x_q <= best_mv_x_d;
      best_mv_y_q <= best_mv_y_d;
      busy_q      <= busy_d;
      col_req_q   <= col_req_d;
      best_vld_q  <= best_vld_d;
    end
  end

  assign busy      = busy_q;
  assign col_req   = col_req_q;
  assign col_idx   = col_idx_q;
  assign best_vld  = best_vld_q;
  assign best_sad  = best_sad_q;
  assign best_mv_x = best_mv_x_q;
  assign best_mv_y = best_mv_y_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// tb_me_search_ctrl
// Self-checking bench for me_search_ctrl. Column results come from small
// per-test tables; the expected winner is the first column holding the
// smallest SAD in the table.

module tb_me_search_ctrl;

  localparam int SAD_W = 14;
  localparam int MV_W  = 4;
  localparam int NCOL  = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             busy;
  logic             col_req;
  logic [MV_W-1:0]  col_idx;
  logic             col_vld;
  logic [SAD_W-1:0] sad_cmp;
  logic [MV_W-1:0]  mv_y;
  logic             best_vld;
  logic             best_rdy;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_mv_x;
  logic [MV_W-1:0]  best_mv_y;

  int colSad [NCOL];
  int colY   [NCOL];
  int checkCount = 0;
  int passCount  = 0;

  me_search_ctrl #(.SAD_W(SAD_W), .MV_W(MV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .col_req   (col_req),
    .col_idx   (col_idx),
    .col_vld   (col_vld),
    .sad_cmp   (sad_cmp),
    .mv_y      (mv_y),
    .best_vld  (best_vld),
    .best_rdy  (best_rdy),
    .best_sad  (best_sad),
    .best_mv_x (best_mv_x),
    .best_mv_y (best_mv_y)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference winner: smallest SAD in the table, first column holding it.
  task automatic refBest(output int s, output int x, output int y);
    int m;
    m = colSad[0];
    foreach (colSad[i]) m = (colSad[i] < m) ? colSad[i] : m;
    x = -1;
    foreach (colSad[i]) if (x < 0 && colSad[i] == m) x = i;
    s = m;
    y = colY[x];
  endtask

  task automatic checkResult(input string tag);
    int s, x, y;
    refBest(s, x, y);
    checkOutput({tag, "_sad"}, int'(best_sad), s);
    checkOutput({tag, "_x"}, int'(best_mv_x), x);
    checkOutput({tag, "_y"}, int'(best_mv_y), y);
  endtask

  // Starts a search and feeds the first numCols columns from the tables,
  // with random col_vld gaps of 0..maxGap cycles before each column.
  task automatic applyStimulus(input int numCols, input int maxGap);
    int gap;
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("req_entry", int'(col_req), 1);
    checkOutput("busy_in_req", int'(busy), 1);
    for (int k = 0; k < numCols; k++) begin
      checkOutput("col_idx", int'(col_idx), k);
      checkOutput("no_early_vld", int'(best_vld), 0);
      gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
      for (int g = 0; g < gap; g++) begin
        col_vld = 1'b0;
        sad_cmp = '0;
        mv_y    = 4'hF;
        tick;
        checkOutput("col_idx_stall", int'(col_idx), k);
        checkOutput("col_req_stall", int'(col_req), 1);
      end
      col_vld = 1'b1;
      sad_cmp = SAD_W'(colSad[k]);
      mv_y    = MV_W'(colY[k]);
      tick;
    end
    col_vld = 1'b0;
    sad_cmp = '0;
    if (numCols == NCOL) begin
      checkOutput("best_vld_rise", int'(best_vld), 1);
      checkOutput("col_req_out", int'(col_req), 0);
    end
  endtask

  // Holds best_rdy low for stall cycles (optionally pulsing start), then
  // completes the handshake and confirms no further result appears.
  task automatic drainResult(input string tag, input int stall, input bit startInStall);
    best_rdy = 1'b0;
    col_vld  = 1'b1;
    sad_cmp  = '0;
    mv_y     = 4'hF;
    for (int i = 0; i < stall; i++) begin
      start = (startInStall && i == 2);
      tick;
      checkOutput({tag, "_hold_vld"}, int'(best_vld), 1);
      checkOutput({tag, "_hold_req"}, int'(col_req), 0);
      checkResult({tag, "_hold"});
    end
    start    = 1'b0;
    col_vld  = 1'b0;
    best_rdy = 1'b1;
    tick;
    best_rdy = 1'b0;
    checkOutput({tag, "_vld_drop"}, int'(best_vld), 0);
    checkOutput({tag, "_idle"}, int'(busy), 0);
    repeat (3) tick;
    checkOutput({tag, "_no_second"}, int'(best_vld), 0);
    checkOutput({tag, "_no_queued"}, int'(col_req), 0);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_col_req"}, int'(col_req), 0);
    checkOutput({tag, "_best_vld"}, int'(best_vld), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    col_vld  = 1'b0;
    sad_cmp  = '0;
    mv_y     = '0;
    best_rdy = 1'b0;

    // Reset held with start asserted: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick;
      checkIdleZero("reset");
      checkOutput("reset_col_idx", int'(col_idx), 0);
      checkOutput("reset_sad", int'(best_sad), 0);
      checkOutput("reset_mvx", int'(best_mv_x), 0);
      checkOutput("reset_mvy", int'(best_mv_y), 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick;
    checkIdleZero("post_reset");

    // Monotonic columns, col_vld always high: column 0 wins.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = 100 + k; colY[k] = k; end
    applyStimulus(NCOL, 0);
    checkResult("mono");
    drainResult("mono", 0, 1'b0);

    // Single minimum in the middle of the window.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = 3983; colY[k] = $urandom_range(0, 15); end
    colSad[9] = 23;
    colY[9]   = 5;
    applyStimulus(NCOL, 0);
    checkResult("middle");
    drainResult("middle", 0, 1'b0);

    // Tie between columns 4 and 12 with random col_vld gaps.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = 45; colY[k] = $urandom_range(0, 15); end
    colSad[4] = 7;  colY[4] = 2;
    colSad[12] = 7; colY[12] = 6;
    applyStimulus(NCOL, 3);
    checkResult("tie");
    drainResult("tie", 0, 1'b0);

    // Backpressure: result holds for 5 cycles, start during stall ignored.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = $urandom_range(0, 16383); colY[k] = $urandom_range(0, 15); end
    applyStimulus(NCOL, 1);
    checkResult("bp");
    drainResult("bp", 5, 1'b1);

    // Abort after column 6, then a fresh search with all-equal columns.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = $urandom_range(0, 16383); colY[k] = $urandom_range(0, 15); end
    applyStimulus(7, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkIdleZero("abort_req");
    repeat (20) tick;
    checkOutput("abort_req_no_result", int'(best_vld), 0);
    for (int k = 0; k < NCOL; k++) begin colSad[k] = 14; colY[k] = $urandom_range(0, 15); end
    applyStimulus(NCOL, 0);
    checkResult("after_abort");
    drainResult("after_abort", 0, 1'b0);

    // Abort while the result is being offered.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = $urandom_range(0, 16383); colY[k] = $urandom_range(0, 15); end
    applyStimulus(NCOL, 2);
    checkResult("abort_out");
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checkIdleZero("abort_out");

    // Reset in the middle of a search discards it.
    applyStimulus(3, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkIdleZero("mid_reset");
    checkOutput("mid_reset_col_idx", int'(col_idx), 0);
    checkOutput("mid_reset_sad", int'(best_sad), 0);

    // Largest legal SAD everywhere, then random small-range tables with ties.
    for (int k = 0; k < NCOL; k++) begin colSad[k] = 16383; colY[k] = $urandom_range(0, 15); end
    applyStimulus(NCOL, 1);
    checkResult("max_sad");
    drainResult("max_sad", 1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NCOL; k++) begin
        colSad[k] = (r % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(16370, 16383));
        colY[k]   = $urandom_range(0, 15);
      end
      applyStimulus(NCOL, 2);
      checkResult("random");
      drainResult("random", $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
